// File: rtl/win_scanner.sv
// win_scanner: sequential K-in-a-row win detector for a ROWS x COLS board.
// A start pulse latches a board snapshot and a player ID. The block then
// evaluates one anchor cell per clock in row-major order. It stops at the
// first anchor where the player owns K cells in a row in some direction.
// Optional feature macro: WIN_SCANNER_DIAG_EN. When it is defined, the
// down-right and down-left diagonals are also checked.
// Handshake: start is sampled only while busy=0. done is a one-cycle pulse.
// player_won, win_row, win_col and win_dir are valid from the done cycle
// and hold until the next accepted start.
module win_scanner #(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int K      = 4,
    parameter int CELL_W = 2,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int BW    = ROWS * COLS * CELL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BW-1:0]     board,
    input  logic [CELL_W-1:0] player_id,
    output logic              busy,
    output logic              done,
    output logic              player_won,
    output logic [RW-1:0]     win_row,
    output logic [CW-1:0]     win_col,
    output logic [1:0]        win_dir
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     board_q;
    logic [CELL_W-1:0] pid_q;
    logic [RW-1:0]     ar_q, ar_d;
    logic [CW-1:0]     ac_q, ac_d;
    logic              done_d, won_d, load;
    logic [RW-1:0]     row_d;
    logic [CW-1:0]     col_d;
    logic [1:0]        dir_d;
    logic              hit_r, hit_d, any_hit, last_anchor;
    logic [1:0]        hit_dir;
`ifdef WIN_SCANNER_DIAG_EN
    logic              hit_dr, hit_dl;
`endif

    // A cell outside the board reads as empty. This lets the compare loops
    // run unguarded, because the fit flags mask any line that does not fit.
    function automatic logic [CELL_W-1:0] cell_at(input int r, input int c);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return '0;
        return board_q[(r * COLS + c) * CELL_W +: CELL_W];
    endfunction

    // Combinational line compare for the current anchor in each direction.
    always_comb begin
        int ar_i, ac_i;
        ar_i  = int'(ar_q);
        ac_i  = int'(ac_q);
        hit_r = (ac_i + K - 1 < COLS);
        hit_d = (ar_i + K - 1 < ROWS);
`ifdef WIN_SCANNER_DIAG_EN
        hit_dr = (ac_i + K - 1 < COLS) && (ar_i + K - 1 < ROWS);
        hit_dl = (ac_i >= K - 1) && (ar_i + K - 1 < ROWS);
`endif
        for (int i = 0; i < K; i++) begin
            if (cell_at(ar_i, ac_i + i) != pid_q) hit_r = 1'b0;
            if (cell_at(ar_i + i, ac_i) != pid_q) hit_d = 1'b0;
`ifdef WIN_SCANNER_DIAG_EN
            if (cell_at(ar_i + i, ac_i + i) != pid_q) hit_dr = 1'b0;
            if (cell_at(ar_i + i, ac_i - i) != pid_q) hit_dl = 1'b0;
`endif
        end
    end

    // Lowest-encoded hitting direction wins.
    always_comb begin
        any_hit = hit_r | hit_d;
        hit_dir = hit_r ? 2'd0 : 2'd1;
`ifdef WIN_SCANNER_DIAG_EN
        any_hit = any_hit | hit_dr | hit_dl;
        if (!hit_r && !hit_d) hit_dir = hit_dr ? 2'd2 : 2'd3;
`endif
        last_anchor = (int'(ar_q) == ROWS - 1) && (int'(ac_q) == COLS - 1);
    end

    // FSM next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        ac_d    = ac_q;
        done_d  = 1'b0;
        won_d   = player_won;
        row_d   = win_row;
        col_d   = win_col;
        dir_d   = win_dir;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SCAN;
                    ar_d    = '0;
                    ac_d    = '0;
                    won_d   = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    dir_d   = 2'd0;
                end
            end
            SCAN: begin
                if (pid_q == '0) begin
                    // Empty is never a winner, so finish without scanning.
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (any_hit) begin
                    done_d  = 1'b1;
                    won_d   = 1'b1;
                    row_d   = ar_q;
                    col_d   = ac_q;
                    dir_d   = hit_dir;
                    state_d = IDLE;
                end else if (last_anchor) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (int'(ac_q) == COLS - 1) begin
                    ac_d = '0;
                    ar_d = ar_q + 1'b1;
                end else begin
                    ac_d = ac_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, anchor counters and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ar_q       <= '0;
            ac_q       <= '0;
            done       <= 1'b0;
            player_won <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            win_dir    <= 2'd0;
        end else begin
            state_q    <= state_d;
            ar_q       <= ar_d;
            ac_q       <= ac_d;
            done       <= done_d;
            player_won <= won_d;
            win_row    <= row_d;
            win_col    <= col_d;
            win_dir    <= dir_d;
        end
    end

    // Snapshot of board and player taken when a start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_q <= '0;
            pid_q   <= '0;
        end else if (load) begin
            board_q <= board;
            pid_q   <= player_id;
        end
    end

    assign busy = (state_q == SCAN);

endmodule

// File: tb/tb_win_scanner.sv
// tb_win_scanner: randomized and directed bench for win_scanner at default
// parameters. It follows whichever WIN_SCANNER_DIAG_EN setting the design
// was built with.
module tb_win_scanner;

    localparam int ROWS = 5, COLS = 5, K = 4, CELL_W = 2;
    localparam int RW = 3, CW = 3, BW = ROWS * COLS * CELL_W;
`ifdef WIN_SCANNER_DIAG_EN
    localparam int NDIRS = 4;
`else
    localparam int NDIRS = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [BW-1:0]     board = '0;
    logic [CELL_W-1:0] player_id = '0;
    logic              busy, done, player_won;
    logic [RW-1:0]     win_row;
    logic [CW-1:0]     win_col;
    logic [1:0]        win_dir;

    int n_cmp = 0;
    int n_bad = 0;

    win_scanner #(.ROWS(ROWS), .COLS(COLS), .K(K), .CELL_W(CELL_W)) dut (
        .clk(clk), .rst(rst), .start(start), .board(board),
        .player_id(player_id), .busy(busy), .done(done),
        .player_won(player_won), .win_row(win_row), .win_col(win_col),
        .win_dir(win_dir)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r,
                                          input int c, input int v);
        logic [BW-1:0] nb;
        nb = b;
        nb[(r * COLS + c) * CELL_W +: CELL_W] = CELL_W'(v);
        return nb;
    endfunction

    // Reference model: walk the anchors in order and each direction vector.
    // Return the expected latency and the expected result.
    task automatic model(input logic [BW-1:0] b, input int p, output int lat,
                         output int won, output int row, output int col,
                         output int dir);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        lat = ROWS * COLS; won = 0; row = 0; col = 0; dir = 0;
        if (p == 0) begin
            lat = 1;
            return;
        end
        for (int n = 0; n < ROWS * COLS; n++) begin
            for (int d = 0; d < NDIRS; d++) begin
                bit ok = 1;
                for (int i = 0; i < K; i++) begin
                    int rr = n / COLS + i * dr[d];
                    int cc = n % COLS + i * dc[d];
                    if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 0;
                    else if (int'(b[(rr * COLS + cc) * CELL_W +: CELL_W]) != p) ok = 0;
                end
                if (ok) begin
                    lat = n + 1; won = 1; row = n / COLS; col = n % COLS; dir = d;
                    return;
                end
            end
        end
    endtask

    // Driver: start a scan and wait for done. Check latency, busy length and
    // the result. With disturb set, pulse start and overwrite the board
    // mid-scan.
    task automatic run_scan(input string tag, input logic [BW-1:0] b,
                            input int p, input bit disturb);
        int lat, won, row, col, dir, k, busy_cnt;
        logic [BW-1:0] full;
        model(b, p, lat, won, row, col, dir);
        @(negedge clk);
        start = 1'b1; board = b; player_id = CELL_W'(p);
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, ".done_low_at_e0"}, int'(done), 0);
        k = 0; busy_cnt = 0;
        while (!done && k < 100) begin
            if (busy) busy_cnt++;
            if (disturb && k == 3) begin
                full = '0;
                for (int i = 0; i < ROWS * COLS; i++) full = put(full, i / COLS, i % COLS, p);
                start = 1'b1; board = full;
            end
            if (disturb && k == 4) start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        check_val({tag, ".latency"}, k, lat);
        check_val({tag, ".busy_cycles"}, busy_cnt, lat);
        check_val({tag, ".busy_at_done"}, int'(busy), 0);
        check_val({tag, ".won"}, int'(player_won), won);
        check_val({tag, ".row"}, int'(win_row), row);
        check_val({tag, ".col"}, int'(win_col), col);
        check_val({tag, ".dir"}, int'(win_dir), dir);
    endtask

    logic [BW-1:0] b_row, b_anti, b_prio, b_rand;

    initial begin
        int p, bias;
        b_row = '0;
        for (int c = 1; c <= 4; c++) b_row = put(b_row, 2, c, 1);
        b_anti = '0;
        for (int i = 0; i < 4; i++) b_anti = put(b_anti, i, 4 - i, 2);
        b_prio = '0;
        for (int i = 0; i < 4; i++) begin
            b_prio = put(b_prio, 0, i, 1);
            b_prio = put(b_prio, i, 0, 1);
        end

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.busy", int'(busy), 0);
        check_val("reset.done", int'(done), 0);
        check_val("reset.won", int'(player_won), 0);
        check_val("reset.row", int'(win_row), 0);
        check_val("reset.col", int'(win_col), 0);
        check_val("reset.dir", int'(win_dir), 0);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        run_scan("row_win", b_row, 1, 0);
        run_scan("anti_diag", b_anti, 2, 0);
        run_scan("empty", '0, 1, 0);
        run_scan("pid_zero", b_row, 0, 0);
        run_scan("priority", b_prio, 1, 0);
        run_scan("snapshot", '0, 3, 1);
        run_scan("wrong_player", b_row, 2, 0);

        // Reset mid-scan
        run_scan("pre_reset", b_row, 1, 0);
        @(negedge clk);
        start = 1'b1; board = '0; player_id = 2'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("midrst.busy", int'(busy), 0);
        check_val("midrst.done", int'(done), 0);
        check_val("midrst.won", int'(player_won), 0);
        @(negedge clk); rst = 1'b0;
        run_scan("after_reset", b_row, 1, 0);

        // Random boards, biased towards the searched player so wins occur
        for (int t = 0; t < 40; t++) begin
            p = $urandom_range(0, 3);
            bias = $urandom_range(40, 90);
            b_rand = '0;
            for (int i = 0; i < ROWS * COLS; i++) begin
                if ($urandom_range(0, 99) < bias) b_rand = put(b_rand, i / COLS, i % COLS, p);
                else b_rand = put(b_rand, i / COLS, i % COLS, $urandom_range(0, 3));
            end
            run_scan($sformatf("rand%0d", t), b_rand, p, 0);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/win_scanner.md
# win_scanner

Parametrised, sequential K-in-a-row win detector for an R×C game board of CELL_W-bit cells. It sits between the board register and the game-control FSM: on a start pulse it latches a board snapshot and a player ID. It then scans one anchor cell per clock and reports whether that player owns K consecutive cells in any enabled direction, plus the location and direction of the first line found.

## Interface
- ROWS, 5, board rows (≥1)
- COLS, 5, board columns (≥1)
- K, 4, run length required to win (≥2)
- CELL_W, 2, bits per cell; value 0 = empty
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request scan; accepted only when busy=0
- board  in  ROWS*COLS*CELL_W  cell (r,c) at bits [r*COLS*CELL_W + c*CELL_W +: CELL_W]
- player_id  in  CELL_W  cell value to search for
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, result valid
- player_won  out  1  win found (held until next accepted start)
- win_row  out  max(1,$clog2(ROWS))  anchor row of first line found
- win_col  out  max(1,$clog2(COLS))  anchor column of first line found
- win_dir  out  2  0 = right, 1 = down, 2 = down-right, 3 = down-left

## Operation
- FSM states: IDLE, SCAN. A fast-fail path from IDLE handles player_id = 0.
- IDLE with start=1:
  - Latch board and player_id into internal registers.
  - Clear player_won, win_row, win_col and win_dir.
  - Anchor index = 0; go to SCAN; busy=1.
- SCAN: each cycle, evaluate the anchor (r,c) in row-major order, index n = r*COLS+c.
  - Test every direction for which the whole line fits on the board:
    - right: c+K-1 < COLS
    - down: r+K-1 < ROWS
    - down-right: both of the above
    - down-left: r+K-1 < ROWS and c ≥ K-1
  - A direction hits if all K cells equal the latched player_id.
- First hit:
  - player_won=1; win_row/win_col = anchor; win_dir = lowest-encoded hitting direction.
  - done=1, busy=0, return to IDLE. The scan terminates early; no further anchors are examined.
- No hit on the last anchor (n = ROWS*COLS-1): done=1, player_won=0, location/direction = 0, return to IDLE.
- If K exceeds both ROWS and COLS, no line fits and the scan always ends with a miss.
- player_id = 0 at start: no scan. done pulses on the next cycle with player_won=0.
- start while busy=1: ignored. board and player_id changes during SCAN are ignored because the scan uses the latched snapshot.
- start in the same cycle done is high: accepted, since the FSM is already in IDLE.

## Timing
- Reset values: busy=0, done=0, player_won=0, win_row=0, win_col=0, win_dir=0; FSM in IDLE.
- Reset asserted mid-scan aborts immediately. No done pulse is produced; the next start after reset release behaves normally.
- Call the rising edge that accepts start E0. Then:
  - busy is high from E0.
  - Anchor n is evaluated in the cycle following edge E0+n.
  - A hit at anchor n gives done=1 and busy=0 after edge E0+n+1 (latency n+1 cycles).
  - A miss gives done after edge E0+ROWS*COLS (worst case 25 cycles at default parameters).
  - player_id = 0 gives done after E0+1.
- done is high for exactly one cycle. player_won and win_* are registered and stable from the done cycle until the next accepted start.
- Hit comparison is combinational within one cycle over at most 4·K cell compares. Outputs are registered.

## Configuration
- WIN_SCANNER_DIAG_EN:
  - Defined: all four directions are checked and win_dir may be 2 or 3.
  - Undefined: only right and down are checked, the diagonal compare logic is not synthesised, and win_dir is only ever 0 or 1.
  - Scan order and latency are unchanged in both builds.

## Test plan
All cases use defaults (5×5, K=4, CELL_W=2) with WIN_SCANNER_DIAG_EN defined unless stated.
- Row win: player 1 at (2,1)-(2,4), rest 0, start with player_id=1 -> done 12 cycles after E0; player_won=1, win_row=2, win_col=1, win_dir=0.
- Anti-diagonal:
  - Player 2 at (0,4),(1,3),(2,2),(3,1), start with player_id=2 -> done 5 cycles after E0; won=1, row=0, col=4, dir=3.
  - Same stimulus with the macro undefined -> done 25 cycles after E0; won=0, row=0, col=0, dir=0.
- Empty board, player_id=1 -> done 25 cycles after E0; won=0; busy high for exactly 25 cycles. Separately, player_id=0 -> done 1 cycle after E0, won=0.
- Priority and snapshot:
  - Player 1 at (0,0)-(0,3) and (0,0)-(3,0) -> done 1 cycle after E0; row=0, col=0, dir=0.
  - During a miss scan, pulse start again and overwrite board with a full win -> no restart; result = miss at 25 cycles.
- Reset mid-scan: assert rst 3 cycles after E0 -> busy/done/player_won immediately 0. Release, start on the row-win board -> correct result at 12 cycles.
